// File: rtl/lfsr_draw_roller.sv
// -----------------------------------------------------------------------------
// lfsr_draw_roller
//   No-repeat random draw engine for the lottery display. A start pulse seeds
//   an LFSR from a free-running counter, looks ahead N shifts to learn where the
//   roll will land, skips seeds until that landing value is unused, reserves it,
//   then plays a slowing roll (intervals INIT..MAX by STEP) that ends on it.
//
// Ports
//   i_clk         clock
//   i_rst_n       asynchronous reset, active low
//   i_start       single-cycle start pulse (debounced)
//   i_clear       clear draw history (IDLE only)
//   o_random_out  displayed value, updated only on roll shifts
//   o_chosen_out  committed history mask, bit v = value v drawn
//   o_busy        high in any state other than IDLE
//   o_done        one-cycle pulse when a roll completes
//   o_exhausted   every value has been reserved
// -----------------------------------------------------------------------------
module lfsr_draw_roller #(
    parameter int unsigned       LFSR_W      = 16,
    parameter logic [LFSR_W-1:0] TAPS        = 16'hB400,
    parameter int unsigned       OUT_BITS    = 4,
    parameter int unsigned       INIT_PERIOD = 5_000_000,
    parameter int unsigned       PERIOD_STEP = 1_000_000,
    parameter int unsigned       MAX_PERIOD  = 25_000_000
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic                   i_clear,
    output logic [OUT_BITS-1:0]    o_random_out,
    output logic [2**OUT_BITS-1:0] o_chosen_out,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_exhausted
);

    localparam int unsigned N_SHIFTS = (MAX_PERIOD - INIT_PERIOD) / PERIOD_STEP + 1;
    localparam int unsigned CNT_W    = $clog2(MAX_PERIOD + 1);
    localparam int unsigned NVAL     = 2**OUT_BITS;

    typedef enum logic [1:0] {S_IDLE, S_LOOK, S_SEARCH, S_ROLL} state_t;

    function automatic logic [LFSR_W-1:0] f_step(input logic [LFSR_W-1:0] x);
        return {x[LFSR_W-2:0], ^(x & TAPS)};
    endfunction

    state_t              r_state,  w_state_nx;
    logic [LFSR_W-1:0]   r_lfsr,   w_lfsr_nx;
    logic [LFSR_W-1:0]   r_seed,   w_seed_nx;
    logic [LFSR_W-1:0]   r_res,    w_res_nx;
    logic [LFSR_W-1:0]   r_time;
    logic [NVAL-1:0]     r_mask,   w_mask_nx;
    logic [NVAL-1:0]     r_chosen, w_chosen_nx;
    logic [OUT_BITS-1:0] r_out,    w_out_nx;
    logic [CNT_W-1:0]    r_cnt,    w_cnt_nx;
    logic [CNT_W-1:0]    r_period, w_period_nx;
    logic                r_done,   w_done_nx;

    logic [LFSR_W-1:0]   w_time_smp;
    logic [LFSR_W-1:0]   w_lfsr_step;
    logic [OUT_BITS-1:0] w_v;
    logic                w_exhausted;

    assign w_exhausted  = &r_mask;
    assign w_time_smp   = (r_time == '0) ? LFSR_W'(1) : r_time;  // all-zero would lock the LFSR
    assign w_lfsr_step  = f_step(r_lfsr);
    assign w_v          = r_res[OUT_BITS-1:0];

    assign o_random_out = r_out;
    assign o_chosen_out = r_chosen;
    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = r_done;
    assign o_exhausted  = w_exhausted;

    always_comb begin
        w_state_nx  = r_state;
        w_lfsr_nx   = r_lfsr;
        w_seed_nx   = r_seed;
        w_res_nx    = r_res;
        w_mask_nx   = r_mask;
        w_chosen_nx = r_chosen;
        w_out_nx    = r_out;
        w_cnt_nx    = r_cnt;
        w_period_nx = r_period;
        w_done_nx   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_clear) begin
                    w_mask_nx   = '0;
                    w_chosen_nx = '0;
                end
                // A clear in the same cycle frees the history, so it also unblocks the start.
                if (i_start && (i_clear || !w_exhausted)) begin
                    w_seed_nx  = w_time_smp;
                    w_res_nx   = w_time_smp;
                    w_cnt_nx   = '0;
                    w_state_nx = S_LOOK;
                end
            end
            S_LOOK: begin
                w_res_nx = f_step(r_res);
                if (r_cnt == CNT_W'(N_SHIFTS - 1)) begin
                    w_cnt_nx   = '0;
                    w_state_nx = S_SEARCH;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            S_SEARCH: begin
                // Stepping seed and lookahead together keeps res = step^N(seed).
                if (r_mask[w_v]) begin
                    w_res_nx  = f_step(r_res);
                    w_seed_nx = f_step(r_seed);
                end else begin
                    w_mask_nx[w_v] = 1'b1;
                    w_lfsr_nx      = r_seed;
                    w_cnt_nx       = '0;
                    w_period_nx    = CNT_W'(INIT_PERIOD);
                    w_state_nx     = S_ROLL;
                end
            end
            S_ROLL: begin
                if (i_start) begin
                    w_chosen_nx = r_mask;
                end
                if (i_start && !w_exhausted) begin
                    w_seed_nx  = w_time_smp;
                    w_res_nx   = w_time_smp;
                    w_cnt_nx   = '0;
                    w_state_nx = S_LOOK;
                end else if (r_cnt == r_period - CNT_W'(1)) begin
                    w_lfsr_nx = w_lfsr_step;
                    w_out_nx  = w_lfsr_step[OUT_BITS-1:0];
                    w_cnt_nx  = '0;
                    if (r_period == CNT_W'(MAX_PERIOD)) begin
                        w_state_nx  = S_IDLE;
                        w_done_nx   = 1'b1;
                        w_chosen_nx = r_mask;
                    end else begin
                        w_period_nx = r_period + CNT_W'(PERIOD_STEP);
                    end
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_lfsr   <= '0;
            r_seed   <= '0;
            r_res    <= '0;
            r_time   <= LFSR_W'(1);
            r_mask   <= '0;
            r_chosen <= '0;
            r_out    <= '0;
            r_cnt    <= '0;
            r_period <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_lfsr   <= w_lfsr_nx;
            r_seed   <= w_seed_nx;
            r_res    <= w_res_nx;
            r_time   <= r_time + LFSR_W'(1);
            r_mask   <= w_mask_nx;
            r_chosen <= w_chosen_nx;
            r_out    <= w_out_nx;
            r_cnt    <= w_cnt_nx;
            r_period <= w_period_nx;
            r_done   <= w_done_nx;
        end
    end

endmodule

// File: tb/tb_lfsr_draw_roller.sv
// -----------------------------------------------------------------------------
// tb_lfsr_draw_roller
//   Directed bench for lfsr_draw_roller with LFSR_W=8, TAPS=8'hB8, OUT_BITS=2,
//   periods 2..4 (N=3 shifts per roll). Expected draws come from a small
//   reference of the lookahead/search rule plus hand-computed constants for the
//   seed 0x05 case (0x05 -> 0x0A -> 0x15 -> 0x2B, value 3; next 0x56, value 2).
// -----------------------------------------------------------------------------
module tb_lfsr_draw_roller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       clear;
    logic [1:0] rnd;
    logic [3:0] chosen;
    logic       busy;
    logic       done;
    logic       exh;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] tc;   // mirror of the free-running time counter
    logic [3:0] m;    // expected history mask

    lfsr_draw_roller #(
        .LFSR_W      (8),
        .TAPS        (8'hB8),
        .OUT_BITS    (2),
        .INIT_PERIOD (2),
        .PERIOD_STEP (1),
        .MAX_PERIOD  (4)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_clear      (clear),
        .o_random_out (rnd),
        .o_chosen_out (chosen),
        .o_busy       (busy),
        .o_done       (done),
        .o_exhausted  (exh)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tc <= 8'd1;
        else        tc <= tc + 8'd1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] stp(input logic [7:0] x);
        return {x[6:0], ^(x & 8'hB8)};
    endfunction

    // Landing value for a seed given the history, and number of SEARCH cycles.
    task automatic model_draw(input logic [7:0] seed, input logic [3:0] mask,
                              output logic [1:0] v, output int s);
        logic [7:0] r;
        r = stp(stp(stp(seed)));
        s = 1;
        while (mask[r[1:0]] && s < 300) begin
            r = stp(r);
            s++;
        end
        v = r[1:0];
    endtask

    // All tasks start and end at posedge+1.
    task automatic pulse(input logic with_clear, output logic [7:0] seed);
        start = 1'b1;
        clear = with_clear;
        seed  = (tc == 8'd0) ? 8'd1 : tc;
        @(posedge clk); #1;
        start = 1'b0;
        clear = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic start_at(input logic [7:0] target);
        int k = 0;
        while (tc != target && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m     = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic run_roll(input logic with_clear, input string tag);
        logic [7:0] seed;
        logic [1:0] v;
        logic [1:0] prev;
        int s, n;
        prev = rnd;
        pulse(with_clear, seed);
        if (with_clear) m = '0;
        chk({tag, "_busy"}, busy, 1'b1);
        chk({tag, "_hold"}, rnd, prev);
        model_draw(seed, m, v, s);
        m[v] = 1'b1;
        wait_done(n);
        chk({tag, "_cyc"}, n, 12 + s);
        chk({tag, "_val"}, rnd, v);
        chk({tag, "_mask"}, chosen, m);
        @(posedge clk); #1;
        chk({tag, "_donepulse"}, done, 1'b0);
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        logic [7:0] seed;
        logic [1:0] v, va, vb;
        int s, sa, sb, n;

        rst_n = 1'b0;
        start = 1'b0;
        clear = 1'b0;
        m     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out",    rnd,    2'd0);
        chk("rst_chosen", chosen, 4'd0);
        chk("rst_busy",   busy,   1'b0);
        chk("rst_done",   done,   1'b0);
        chk("rst_exh",    exh,    1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: seed 0x05 lands on 3 after 3 + 1 + 9 cycles
        start_at(8'd5);
        run_roll(1'b0, "t1");
        chk("t1_hand_val",  rnd,    2'd3);
        chk("t1_hand_mask", chosen, 4'b1000);

        // 5: seed 0x05 again; 3 is taken so SEARCH takes two cycles and lands on 2
        start_at(8'd5);
        pulse(1'b0, seed);
        model_draw(seed, m, v, s);
        m[v] = 1'b1;
        repeat (3 + s) @(posedge clk);
        #1;
        chk("t5_hold_roll0", rnd, 2'd3);
        wait_done(n);
        chk("t5_cyc",       n,      9);
        chk("t5_val",       rnd,    v);
        chk("t5_hand_val",  rnd,    2'd2);
        chk("t5_hand_mask", chosen, 4'b1100);

        // 6: asynchronous reset mid-roll clears everything, then behaves as test 1
        pulse(1'b0, seed);
        model_draw(seed, m, v, s);
        repeat (3 + s + 2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        m     = '0;
        #1;
        chk("t6_async_zero", {rnd, chosen, busy, done, exh}, 9'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_at(8'd5);
        run_roll(1'b0, "t6");
        chk("t6_hand_val", rnd, 2'd3);

        // 2: four complete rolls exhaust the values; a fifth start is ignored
        do_reset();
        run_roll(1'b0, "t2a");
        run_roll(1'b0, "t2b");
        run_roll(1'b0, "t2c");
        run_roll(1'b0, "t2d");
        chk("t2_full", chosen, 4'hF);
        chk("t2_exh",  exh,    1'b1);
        pulse(1'b0, seed);
        chk("t2_fifth_busy", busy, 1'b0);

        // 3: clear and start together while exhausted
        run_roll(1'b1, "t3");
        chk("t3_exh", exh, 1'b0);

        // 4: restart three cycles into ROLL
        do_reset();
        pulse(1'b0, seed);
        model_draw(seed, m, va, sa);
        repeat (3 + sa + 3) @(posedge clk);
        #1;
        chk("t4_rolling", busy, 1'b1);
        pulse(1'b0, seed);
        m[va] = 1'b1;
        chk("t4_commit_first", chosen, m);
        chk("t4_busy", busy, 1'b1);
        model_draw(seed, m, vb, sb);
        m[vb] = 1'b1;
        wait_done(n);
        chk("t4_cyc",  n,      12 + sb);
        chk("t4_val",  rnd,    vb);
        chk("t4_mask", chosen, m);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
